paddle_array: RTL and testbench
===============================

PADDLE_ARRAY -- requirements
Module: paddle_array

Interface
REQ-001 SHALL have parameter N_PADDLES, default 2, number of independent paddle channels.
REQ-002 SHALL have parameter POS_W, default 10, width of each position value.
REQ-003 SHALL have parameter Y_MAX, default 600, screen height in pixels.
REQ-004 SHALL have parameter HALF_H, default 32, paddle half-height; legal centre range is MIN_POS=HALF_H to MAX_POS=Y_MAX-HALF_H.
REQ-005 SHALL have parameter TICK_W, default 20, width of the tick counter and threshold.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port game_on, input, 1, enables motion globally.
REQ-009 SHALL have port wrap_mode, input, 1; 1 = wrap at edges, 0 = clamp.
REQ-010 SHALL have port accel_en, input, 1, enables hold-to-accelerate.
REQ-011 SHALL have port center, input, 1, synchronous recentre of all paddles.
REQ-012 SHALL have ports up and down, input, N_PADDLES each, per-channel buttons.
REQ-013 SHALL have port ticks_per_px, input, TICK_W, base cycles per pixel step, shared by all channels.
REQ-014 SHALL have port position, output, N_PADDLES*POS_W; channel i occupies bits [i*POS_W +: POS_W].
REQ-015 SHALL have ports moving_up and moving_down, output, N_PADDLES each, one-cycle step strobes.
REQ-016 SHALL have port at_limit, output, N_PADDLES; high while position equals MIN_POS or MAX_POS.

Function
REQ-017 SHALL keep a per-channel TICK_W tick counter, accel level (0..2) and step count (0..7).
REQ-018 SHALL define T_eff = max(ticks_per_px >> level, 1), where level is 0 when accel_en=0.
REQ-019 SHALL treat a channel as active on an edge when game_on=1 and exactly one of up[i] or down[i] is 1.
REQ-020 On an active edge, if counter = T_eff-1 the channel SHALL step 1 pixel and clear the counter; otherwise it SHALL increment the counter. A step therefore lands on the T_eff-th consecutive active edge.
REQ-021 If counter >= T_eff-1 because ticks_per_px shrank mid-hold, the channel SHALL step on the next active edge.
REQ-022 up SHALL increase position; down SHALL decrease it.
REQ-023 On any non-active edge (no button, both buttons, or game_on=0), the channel SHALL clear the counter, level and step count and hold position.
REQ-024 A direction change between active edges SHALL clear the counter, level and step count before counting.
REQ-025 When accel_en=1, each step SHALL increment the step count; at 8 steps, level SHALL increment (saturating at 2) and the step count SHALL clear.
REQ-026 In clamp mode, a step beyond MIN_POS or MAX_POS SHALL leave position unchanged, assert no moving strobe, and still clear the counter.
REQ-027 In wrap mode, a step up from MAX_POS SHALL go to MIN_POS and a step down from MIN_POS SHALL go to MAX_POS; the strobe SHALL assert.
REQ-028 moving_up[i] and moving_down[i] SHALL be registered and high only on the cycle after the edge that updated position.
REQ-029 center=1 SHALL set every position to Y_MAX/2 and clear all counters, levels and strobes on that edge, overriding steps.
REQ-030 Channels SHALL be fully independent; simultaneous steps on several channels SHALL all take effect on the same edge.

Reset
REQ-031 reset=0 SHALL immediately set every position to Y_MAX/2; moving_up, moving_down and at_limit to 0; and all counters, levels and step counts to 0, regardless of clk.
REQ-032 Deassertion SHALL resume normal counting from zero on the next active edge; reset mid-step SHALL discard the pending step.

Verification
REQ-033 Reset pulse mid-motion -> all positions 300, all strobes 0, at_limit 0, asynchronously.
REQ-034 tpp=4, game_on=1, up[0] held -> position[0]=301 after 4th edge, 302 after 8th; moving_up[0] high 1 cycle each; channel 1 stays 300.
REQ-035 Clamp mode, position 568, up held -> stays 568, at_limit=1, no strobe; wrap_mode=1 -> next step gives 32 with moving_up pulse.
REQ-036 up&down both held 20 cycles with tpp=4 -> no change; release down -> first step 4 edges later.
REQ-037 accel_en=1, tpp=8, up held -> 8 steps at 8-cycle spacing, 8 at 4, then every 2; release for 1 cycle -> spacing returns to 8.
REQ-038 center pulse while both channels are moving -> both positions 300 next cycle, counters restart, no strobe that cycle.

Source files
------------

// File: rtl/paddle_array.sv
// Multi-channel paddle position tracker: per-channel hold-to-move with tick
// pacing, optional acceleration, clamp or wrap at the screen edges.
module paddle_array #(
  parameter int N_PADDLES = 2,
  parameter int POS_W     = 10,
  parameter int Y_MAX     = 600,
  parameter int HALF_H    = 32,
  parameter int TICK_W    = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         game_on,
  input  logic                         wrap_mode,
  input  logic                         accel_en,
  input  logic                         center,
  input  logic [N_PADDLES-1:0]         up,
  input  logic [N_PADDLES-1:0]         down,
  input  logic [TICK_W-1:0]            ticks_per_px,
  output logic [N_PADDLES*POS_W-1:0]   position,
  output logic [N_PADDLES-1:0]         moving_up,
  output logic [N_PADDLES-1:0]         moving_down,
  output logic [N_PADDLES-1:0]         at_limit
);

  localparam logic [POS_W-1:0]  MIN_POS  = POS_W'(HALF_H);
  localparam logic [POS_W-1:0]  MAX_POS  = POS_W'(Y_MAX - HALF_H);
  localparam logic [POS_W-1:0]  CTR_POS  = POS_W'(Y_MAX / 2);
  localparam logic [POS_W-1:0]  POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [TICK_W-1:0] TICK_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < N_PADDLES; gi++) begin : g_ch
      logic [POS_W-1:0]  pos_reg, pos_next;
      logic [TICK_W-1:0] cnt_reg, cnt_next;
      logic [1:0]        level_reg, level_next;
      logic [2:0]        steps_reg, steps_next;
      logic              dir_reg, dir_next;
      logic              up_reg, up_next;
      logic              dn_reg, dn_next;

      logic              active, changed, fire;
      logic [TICK_W-1:0] base_cnt, shifted, t_eff;
      logic [1:0]        base_level, eff_level;
      logic [2:0]        base_steps;

      always_comb begin
        active     = game_on & (up[gi] ^ down[gi]);
        // A reversal restarts the pacing as if the button had just been pressed.
        changed    = (dir_reg != up[gi]);
        base_cnt   = changed ? '0 : cnt_reg;
        base_level = changed ? 2'd0 : level_reg;
        base_steps = changed ? 3'd0 : steps_reg;
        eff_level  = accel_en ? base_level : 2'd0;
        shifted    = ticks_per_px >> eff_level;
        t_eff      = (shifted == '0) ? TICK_ONE : shifted;
        // >= so a threshold that shrank mid-hold fires on the next edge.
        fire       = (base_cnt >= t_eff - TICK_ONE);

        pos_next   = pos_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        steps_next = steps_reg;
        dir_next   = dir_reg;
        up_next    = 1'b0;
        dn_next    = 1'b0;

        if (center) begin
          pos_next   = CTR_POS;
          cnt_next   = '0;
          level_next = 2'd0;
          steps_next = 3'd0;
        end else if (!active) begin
          cnt_next   = '0;
          level_next = 2'd0;
          steps_next = 3'd0;
        end else begin
          dir_next = up[gi];
          if (fire) begin
            cnt_next = '0;
            if (up[gi]) begin
              if (pos_reg >= MAX_POS) begin
                if (wrap_mode) begin
                  pos_next = MIN_POS;
                  up_next  = 1'b1;
                end
              end else begin
                pos_next = pos_reg + POS_ONE;
                up_next  = 1'b1;
              end
            end else begin
              if (pos_reg <= MIN_POS) begin
                if (wrap_mode) begin
                  pos_next = MAX_POS;
                  dn_next  = 1'b1;
                end
              end else begin
                pos_next = pos_reg - POS_ONE;
                dn_next  = 1'b1;
              end
            end
            if (!accel_en) begin
              level_next = 2'd0;
              steps_next = 3'd0;
            end else if (base_steps == 3'd7) begin
              steps_next = 3'd0;
              level_next = (base_level == 2'd2) ? 2'd2 : base_level + 2'd1;
            end else begin
              steps_next = base_steps + 3'd1;
              level_next = base_level;
            end
          end else begin
            cnt_next   = base_cnt + TICK_ONE;
            level_next = accel_en ? base_level : 2'd0;
            steps_next = accel_en ? base_steps : 3'd0;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pos_reg   <= CTR_POS;
          cnt_reg   <= '0;
          level_reg <= 2'd0;
          steps_reg <= 3'd0;
          dir_reg   <= 1'b0;
          up_reg    <= 1'b0;
          dn_reg    <= 1'b0;
        end else begin
          pos_reg   <= pos_next;
          cnt_reg   <= cnt_next;
          level_reg <= level_next;
          steps_reg <= steps_next;
          dir_reg   <= dir_next;
          up_reg    <= up_next;
          dn_reg    <= dn_next;
        end
      end

      assign position[gi*POS_W +: POS_W] = pos_reg;
      assign moving_up[gi]   = up_reg;
      assign moving_down[gi] = dn_reg;
      assign at_limit[gi]    = (pos_reg == MIN_POS) || (pos_reg == MAX_POS);
    end
  endgenerate

endmodule

// File: tb/tb_paddle_array.sv
// Directed bench for paddle_array: expected step strobes are queued as stimulus
// is applied and matched (channel, direction, position, cycle) when they appear.
module tb_paddle_array;
  localparam int N  = 2;
  localparam int PW = 10;
  localparam int TW = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              game_on = 1'b0;
  logic              wrap_mode = 1'b0;
  logic              accel_en = 1'b0;
  logic              center = 1'b0;
  logic [N-1:0]      up = '0;
  logic [N-1:0]      down = '0;
  logic [TW-1:0]     ticks_per_px = 20'd4;
  logic [N*PW-1:0]   position;
  logic [N-1:0]      moving_up;
  logic [N-1:0]      moving_down;
  logic [N-1:0]      at_limit;

  paddle_array dut (
    .clk(clk), .reset(reset), .game_on(game_on), .wrap_mode(wrap_mode),
    .accel_en(accel_en), .center(center), .up(up), .down(down),
    .ticks_per_px(ticks_per_px), .position(position), .moving_up(moving_up),
    .moving_down(moving_down), .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    bit is_up;
    int pos;
    int at;
  } ev_t;
  ev_t exp_q[$];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  function automatic int pos_of(input int i);
    return int'(position[i*PW +: PW]);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_step(input int ch, input bit is_up, input int pos, input int at);
    ev_t e;
    e.ch = ch; e.is_up = is_up; e.pos = pos; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic recentre();
    center = 1'b1;
    tick(1);
    center = 1'b0;
  endtask

  // Every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        if (moving_up[i] || moving_down[i]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe_ch", i, -1);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_ch", i, e.ch);
            chk("strobe_dir", int'(moving_up[i]), int'(e.is_up));
            chk("strobe_pos", pos_of(i), e.pos);
            chk("strobe_cycle", cyc, e.at);
          end
        end
      end
    end
  end

  initial begin
    int c;
    int t;
    int p;

    // Reset state
    tick(2);
    chk("rst_pos0", pos_of(0), 300);
    chk("rst_pos1", pos_of(1), 300);
    chk("rst_mu", int'(moving_up), 0);
    chk("rst_md", int'(moving_down), 0);
    chk("rst_lim", int'(at_limit), 0);
    reset = 1'b1;
    tick(1);

    // Basic stepping, tpp=4, channel 0 up
    ticks_per_px = 20'd4;
    game_on = 1'b1;
    up = 2'b01;
    c = cyc;
    expect_step(0, 1'b1, 301, c + 4);
    expect_step(0, 1'b1, 302, c + 8);
    tick(8);
    chk("basic_pos0", pos_of(0), 302);
    chk("basic_pos1", pos_of(1), 300);
    tick(4);
    chk("prereset_pos0", pos_of(0), 303);

    // Asynchronous reset in the strobe cycle, mid-motion
    reset = 1'b0;
    #1;
    chk("async_pos0", pos_of(0), 300);
    chk("async_pos1", pos_of(1), 300);
    chk("async_mu", int'(moving_up), 0);
    chk("async_md", int'(moving_down), 0);
    chk("async_lim", int'(at_limit), 0);
    exp_q.delete();
    #1;
    reset = 1'b1;
    c = cyc;
    expect_step(0, 1'b1, 301, c + 4);
    tick(4);
    chk("resume_pos0", pos_of(0), 301);
    up = 2'b00;
    tick(1);
    recentre();
    chk("recentre_pos0", pos_of(0), 300);

    // Both buttons held: no motion; release down on both channels
    up = 2'b11;
    down = 2'b11;
    tick(20);
    chk("both_pos0", pos_of(0), 300);
    chk("both_pos1", pos_of(1), 300);
    down = 2'b00;
    c = cyc;
    expect_step(0, 1'b1, 301, c + 4);
    expect_step(1, 1'b1, 301, c + 4);
    tick(4);
    chk("release_pos1", pos_of(1), 301);
    up = 2'b00;
    recentre();

    // Acceleration: 8 steps at 8, 8 at 4, then every 2
    accel_en = 1'b1;
    ticks_per_px = 20'd8;
    up = 2'b01;
    c = cyc;
    t = c;
    p = 300;
    for (int k = 0; k < 20; k++) begin
      t += (k < 8) ? 8 : (k < 16) ? 4 : 2;
      p++;
      expect_step(0, 1'b1, p, t);
    end
    tick(t - c);
    chk("accel_pos0", pos_of(0), 320);
    up = 2'b00;
    tick(1);
    up = 2'b01;
    c = cyc;
    expect_step(0, 1'b1, 321, c + 8);
    tick(8);
    chk("accel_reset_pos0", pos_of(0), 321);
    up = 2'b00;
    accel_en = 1'b0;
    recentre();

    // Centre pulse on the edge that would have stepped both channels
    ticks_per_px = 20'd4;
    up = 2'b11;
    tick(3);
    center = 1'b1;
    c = cyc;
    tick(1);
    center = 1'b0;
    chk("center_pos0", pos_of(0), 300);
    chk("center_pos1", pos_of(1), 300);
    expect_step(0, 1'b1, 301, c + 5);
    expect_step(1, 1'b1, 301, c + 5);
    tick(4);
    chk("center_resume_pos1", pos_of(1), 301);
    up = 2'b00;
    recentre();

    // Clamp at top, then wrap both ways
    wrap_mode = 1'b0;
    ticks_per_px = 20'd1;
    up = 2'b01;
    c = cyc;
    for (int k = 1; k <= 268; k++) expect_step(0, 1'b1, 300 + k, c + k);
    tick(278);
    chk("clamp_pos0", pos_of(0), 568);
    chk("clamp_lim0", int'(at_limit[0]), 1);
    chk("clamp_lim1", int'(at_limit[1]), 0);
    wrap_mode = 1'b1;
    expect_step(0, 1'b1, 32, cyc + 1);
    tick(1);
    chk("wrap_up_pos0", pos_of(0), 32);
    chk("wrap_up_lim0", int'(at_limit[0]), 1);
    up = 2'b00;
    down = 2'b01;
    expect_step(0, 1'b0, 568, cyc + 1);
    tick(1);
    chk("wrap_dn_pos0", pos_of(0), 568);
    down = 2'b00;
    tick(2);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
